// File: rtl/if_fetch_unit_pkg.sv
// Shared encodings and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        PCSRC_NONE   = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_VECTOR = 2'b11
    } pcsrc_e;

    // IDLE: nothing outstanding; WAIT: response pending; DROP: pending response is stale
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DROP = 2'b10
    } fetch_state_e;

    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant + response-valid bus.
interface if_fetch_unit_if #(
    parameter int XLEN   = 32,
    parameter int INST_W = 32
);
    logic              req;
    logic [XLEN-1:0]   addr;
    logic              gnt;
    logic              rvalid;
    logic [INST_W-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_fetch_unit_fetch_queue.sv
// Synchronous FIFO holding {pc, instruction} pairs ahead of decode; flush empties it.
module fetch_queue
    import if_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_head_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; entries are only visible once written,
    // and the head output is forced to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count     = r_count;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select, single-outstanding imem
// request FSM and a fetch queue in front of decode.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              INST_W   = 32,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect,
    input  logic [1:0]         pcsource,
    input  logic [XLEN-1:0]    pc_branch,
    input  logic [XLEN-1:0]    pc_jump,
    input  logic [XLEN-1:0]    pc_vector,
    if_fetch_unit_if.master    imem,
    output logic               inst_valid,
    output logic [INST_W-1:0]  inst,
    output logic [XLEN-1:0]    inst_pc,
    input  logic               inst_ready
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_tag_pc;
    logic             r_active;

    logic             w_redir;
    logic [XLEN-1:0]  w_target;
    logic             w_pop;
    logic             w_push;
    logic             w_req;
    logic             w_grant;
    logic             w_room;
    logic [OW-1:0]    w_occupancy;
    logic [CW-1:0]    w_count;
    logic [XLEN+INST_W-1:0] w_head;

    assign w_redir = redirect && (pcsrc_e'(pcsource) != PCSRC_NONE);
    assign w_pop   = inst_valid && inst_ready;

    // Entries held after this cycle plus the response still owed to us in WAIT.
    assign w_occupancy = OW'(w_count) - OW'(w_pop) + OW'(r_state == WAIT);
    assign w_room      = (w_occupancy < OW'(FQ_DEPTH));

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_target = r_pc;
        unique case (pcsrc_e'(pcsource))
            PCSRC_BRANCH: w_target = pc_branch;
            PCSRC_JUMP:   w_target = pc_jump;
            PCSRC_VECTOR: w_target = pc_vector;
            default:      w_target = r_pc;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = r_active && !w_redir && w_room &&
                      ((r_state == IDLE) || imem.rvalid);
        w_grant     = w_req && imem.gnt;
        w_push      = (r_state == WAIT) && imem.rvalid && !w_redir;

        unique case (r_state)
            IDLE: if (w_grant) w_state_nxt = WAIT;
            WAIT: begin
                if (imem.rvalid)  w_state_nxt = w_grant ? WAIT : IDLE;
                else if (w_redir) w_state_nxt = DROP;
            end
            DROP: if (imem.rvalid) w_state_nxt = w_grant ? WAIT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_tag_pc <= '0;
            r_active <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
            r_active <= 1'b1;
            r_state  <= w_state_nxt;
            if (w_redir)      r_pc <= w_target;
            else if (w_grant) r_pc <= r_pc + XLEN'(PC_INCR);
            if (w_grant)      r_tag_pc <= r_pc;
        end
    end

    fetch_queue #(
        .WIDTH (XLEN + INST_W),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({r_tag_pc, imem.rdata}),
        .i_pop       (w_pop),
        .i_flush     (w_redir),
        .o_head_data (w_head),
        .o_count     (w_count)
    );

    assign imem.req   = w_req;
    assign imem.addr  = r_pc;
    assign inst_valid = (w_count != '0);
    assign inst_pc    = w_head[XLEN+INST_W-1:INST_W];
    assign inst       = w_head[INST_W-1:0];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; a second instance with RESET_PC at the top of
// the address space runs in lockstep to show PC wrap.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [1:0]  pcsource;
    logic [31:0] pc_branch, pc_jump, pc_vector;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        inst_ready;

    logic        inst_valid, inst_valid_w;
    logic [31:0] inst, inst_w, inst_pc, inst_pc_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_fetch_unit_if #(.XLEN(32), .INST_W(32)) u_imem ();
    if_fetch_unit_if #(.XLEN(32), .INST_W(32)) u_imem_w ();

    assign u_imem.gnt      = gnt;
    assign u_imem.rvalid   = rvalid;
    assign u_imem.rdata    = rdata;
    assign u_imem_w.gnt    = gnt;
    assign u_imem_w.rvalid = rvalid;
    assign u_imem_w.rdata  = rdata;

    if_fetch_unit #(.XLEN(32), .INST_W(32), .FQ_DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .pcsource   (pcsource),
        .pc_branch  (pc_branch),
        .pc_jump    (pc_jump),
        .pc_vector  (pc_vector),
        .imem       (u_imem.master),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    if_fetch_unit #(.XLEN(32), .INST_W(32), .FQ_DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .pcsource   (pcsource),
        .pc_branch  (pc_branch),
        .pc_jump    (pc_jump),
        .pc_vector  (pc_vector),
        .imem       (u_imem_w.master),
        .inst_valid (inst_valid_w),
        .inst       (inst_w),
        .inst_pc    (inst_pc_w),
        .inst_ready (inst_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; pcsource = 2'b00;
        pc_branch = 32'h0; pc_jump = 32'h0; pc_vector = 32'h0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; inst_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_req", u_imem.req, 1'b0);
        check("rst_addr", u_imem.addr, 32'h0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_addr_wrap", u_imem_w.addr, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        tick();

        // 1: streaming fetch, gnt=1, rvalid one cycle after grant, decode always ready
        gnt = 1'b1; inst_ready = 1'b1; settle();
        check("t1_req0", u_imem.req, 1'b1);
        check("t1_addr0", u_imem.addr, 32'h0);
        check("t5_addr0_wrap", u_imem_w.addr, 32'hFFFF_FFFC);
        tick();
        rvalid = 1'b1; rdata = 32'hA000_0000; settle();
        check("t1_addr1", u_imem.addr, 32'h4);
        check("t5_addr1_wrap", u_imem_w.addr, 32'h0);
        check("t1_valid_early", inst_valid, 1'b0);
        tick();
        rdata = 32'hA000_0004; settle();
        check("t1_valid0", inst_valid, 1'b1);
        check("t1_inst0", inst, 32'hA000_0000);
        check("t1_pc0", inst_pc, 32'h0);
        check("t1_addr2", u_imem.addr, 32'h8);
        tick();
        rdata = 32'hA000_0008; gnt = 1'b0; settle();
        check("t1_pc1", inst_pc, 32'h4);
        check("t1_inst1", inst, 32'hA000_0004);
        check("t1_addr3", u_imem.addr, 32'hC);
        tick();
        rvalid = 1'b0; inst_ready = 1'b0; settle();
        check("t1_pc2", inst_pc, 32'h8);
        check("t1_hold_req", u_imem.req, 1'b1);
        check("t1_hold_addr", u_imem.addr, 32'hC);
        tick();

        // 2: decode stalled, queue fills to 4 entries and requests stop
        gnt = 1'b1; tick();
        rvalid = 1'b1; rdata = 32'hA000_000C; tick();
        rdata = 32'hA000_0010; tick();
        rdata = 32'hA000_0014; settle();
        check("t2_req_full_pending", u_imem.req, 1'b0);
        tick();
        rvalid = 1'b0; settle();
        check("t2_req_full", u_imem.req, 1'b0);
        check("t2_head_pc", inst_pc, 32'h8);
        check("t2_head_inst", inst, 32'hA000_0008);
        tick();
        inst_ready = 1'b1; settle();
        check("t2_req_after_pop", u_imem.req, 1'b1);
        check("t2_addr_after_pop", u_imem.addr, 32'h18);
        tick();
        inst_ready = 1'b0; settle();
        check("t2_head_after_pop", inst_pc, 32'hC);
        check("t2_req_wait", u_imem.req, 1'b0);

        // 3: jump redirect while a response is pending
        redirect = 1'b1; pcsource = 2'b10; pc_jump = 32'h100; settle();
        check("t3_req_redirect", u_imem.req, 1'b0);
        tick();
        redirect = 1'b0; settle();
        check("t3_flushed", inst_valid, 1'b0);
        check("t3_addr", u_imem.addr, 32'h100);
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; settle();
        check("t3_req_on_stale", u_imem.req, 1'b1);
        tick();
        rdata = 32'hB000_0100; gnt = 1'b0; settle();
        check("t3_stale_dropped", inst_valid, 1'b0);
        check("t3_addr_next", u_imem.addr, 32'h104);
        tick();
        rvalid = 1'b0; settle();
        check("t3_valid", inst_valid, 1'b1);
        check("t3_pc", inst_pc, 32'h100);
        check("t3_inst", inst, 32'hB000_0100);

        // 4: redirect with coincident rvalid and dequeue, then pcsource=00
        gnt = 1'b1; tick();
        gnt = 1'b0; redirect = 1'b1; pcsource = 2'b01; pc_branch = 32'h200;
        rvalid = 1'b1; rdata = 32'hC000_0104; inst_ready = 1'b1; settle();
        check("t4_head_taken", inst_pc, 32'h100);
        check("t4_req_redirect", u_imem.req, 1'b0);
        tick();
        redirect = 1'b0; rvalid = 1'b0; settle();
        check("t4_no_resp", inst_valid, 1'b0);
        check("t4_req_target", u_imem.req, 1'b1);
        check("t4_addr_target", u_imem.addr, 32'h200);
        tick();
        redirect = 1'b1; pcsource = 2'b00; pc_branch = 32'h300; pc_jump = 32'h300;
        pc_vector = 32'h300; gnt = 1'b1; settle();
        check("t4_none_req", u_imem.req, 1'b1);
        check("t4_none_addr", u_imem.addr, 32'h200);
        tick();
        redirect = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'hD000_0200; tick();
        rvalid = 1'b0; settle();
        check("t4_none_valid", inst_valid, 1'b1);
        check("t4_none_pc", inst_pc, 32'h200);
        check("t4_none_inst", inst, 32'hD000_0200);
        tick();

        // 6: reset while WAIT with the queue full of owed entries
        inst_ready = 1'b0; gnt = 1'b1; tick();
        rvalid = 1'b1; rdata = 32'hE000_0000; tick();
        tick();
        tick();
        rvalid = 1'b0; rst_n = 1'b0; settle();
        check("t6_req", u_imem.req, 1'b0);
        check("t6_addr", u_imem.addr, 32'h0);
        check("t6_valid", inst_valid, 1'b0);
        check("t6_inst", inst, 32'h0);
        check("t6_pc", inst_pc, 32'h0);
        tick();
        rst_n = 1'b1; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h5A5A_5A5A; tick();
        settle();
        check("t6_req_after", u_imem.req, 1'b1);
        check("t6_addr_after", u_imem.addr, 32'h0);
        tick();
        rvalid = 1'b0; settle();
        check("t6_stale_ignored", inst_valid, 1'b0);
        gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hF000_0000; tick();
        rvalid = 1'b0; settle();
        check("t6_first_valid", inst_valid, 1'b1);
        check("t6_first_pc", inst_pc, 32'h0);
        check("t6_first_inst", inst, 32'hF000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
